counter_mod_n: RTL and testbench

//   Parametrised modulo-N up/down counter, successor to the fixed 3-bit free-running counter.

---
 rtl/counter_pkg.sv | 18 +
 rtl/counter_gray_enc.sv | 17 +
 rtl/counter_mod_n.sv | 112 +++++++++++
 tb/tb_counter_mod_n.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and defaults for the modulo-N counter.
// Direction encoding, Gray helper and parameter defaults.
package counter_pkg;

    typedef enum logic {
        CNT_DOWN = 1'b0,
        CNT_UP   = 1'b1
    } cnt_dir_t;

    localparam int DEF_WIDTH   = 3;
    localparam int DEF_MODULUS = 8;
    localparam int DEF_WRAP_W  = 8;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/counter_gray_enc.sv
// Combinational binary to Gray encoder.
// Fed with the next count so the Gray register tracks q exactly.
module counter_gray_enc
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    // Adjacent-bit XOR gives the reflected Gray code.
    always_comb begin
        gray = bin ^ (bin >> 1);
    end

endmodule

// File: rtl/counter_mod_n.sv
// Modulo-N up/down counter with clear, load, terminal count and wrap stats.
// Optional Gray output enabled by defining COUNTER_MOD_N_GRAY_EN.
module counter_mod_n
    import counter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MODULUS = DEF_MODULUS,
    parameter int WRAP_W  = DEF_WRAP_W
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              en,
    input  logic              up_dn,
    input  logic              clr,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  q,
    output logic              tc,
    output logic              wrap,
    output logic [WRAP_W-1:0] wrap_cnt
`ifdef COUNTER_MOD_N_GRAY_EN
    ,
    output logic [WIDTH-1:0]  q_gray
`endif
);

    if (WIDTH < 1 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_param
        $error("counter_mod_n: need WIDTH>=1 and 2<=MODULUS<=2**WIDTH");
    end

    localparam logic [WIDTH:0]    LAST_EXT = (WIDTH + 1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0]  LAST     = WIDTH'(MODULUS - 1);
    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic              wrap_q, wrap_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic [WIDTH:0]    cnt_ext, load_ext;
    logic              at_top, at_zero, tc_c;
    cnt_dir_t          dir;

    // Next-state: clr beats load beats count; comparisons in WIDTH+1 bits.
    always_comb begin
        cnt_d      = cnt_q;
        wrap_cnt_d = wrap_cnt_q;
        cnt_ext    = {1'b0, cnt_q};
        load_ext   = {1'b0, load_val};
        at_top     = (cnt_ext == LAST_EXT);
        at_zero    = (cnt_ext == '0);
        dir        = cnt_dir_t'(up_dn);
        tc_c       = en & ~clr & ~load &
                     (((dir == CNT_UP) & at_top) |
                      ((dir == CNT_DOWN) & at_zero));
        wrap_d     = tc_c;
        if (clr) begin
            cnt_d      = '0;
            wrap_cnt_d = '0;
        end else if (load) begin
            cnt_d = (load_ext > LAST_EXT) ? LAST : load_val;
        end else if (en) begin
            if (dir == CNT_UP) begin
                cnt_d = at_top ? '0 : cnt_q + 1'b1;
            end else begin
                cnt_d = at_zero ? LAST : cnt_q - 1'b1;
            end
            if (tc_c && wrap_cnt_q != WRAP_MAX) begin
                wrap_cnt_d = wrap_cnt_q + 1'b1;
            end
        end
    end

`ifdef COUNTER_MOD_N_GRAY_EN
    logic [WIDTH-1:0] gray_d, gray_q;

    counter_gray_enc #(
        .WIDTH(WIDTH)
    ) u_gray (
        .bin (cnt_d),
        .gray(gray_d)
    );

    // Gray register loads from next count, so it never lags q.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            gray_q <= '0;
        end else begin
            gray_q <= gray_d;
        end
    end

    assign q_gray = gray_q;
`endif

    // Count, wrap pulse and wrap statistics registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            wrap_q     <= 1'b0;
            wrap_cnt_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            wrap_q     <= wrap_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign q        = cnt_q;
    assign tc       = tc_c;
    assign wrap     = wrap_q;
    assign wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_counter_mod_n.sv
// Directed plus randomized bench for counter_mod_n (W=3, M=6, WRAP_W=2).
// Reference model uses plain modular arithmetic on integers.
module tb_counter_mod_n;

    localparam int W  = 3;
    localparam int M  = 6;
    localparam int WW = 2;
    localparam int WMAX = (1 << WW) - 1;

    logic          clock;
    logic          rst_n;
    logic          en;
    logic          up_dn;
    logic          clr;
    logic          load;
    logic [W-1:0]  load_val;
    logic [W-1:0]  q;
    logic          tc;
    logic          wrap;
    logic [WW-1:0] wrap_cnt;
`ifdef COUNTER_MOD_N_GRAY_EN
    logic [W-1:0]  q_gray;
`endif

    int checks = 0;
    int errors = 0;

    int mq = 0;
    int mw = 0;
    int mc = 0;
    bit gray_chk = 0;

    counter_mod_n #(
        .WIDTH  (W),
        .MODULUS(M),
        .WRAP_W (WW)
    ) dut (
        .clock   (clock),
        .rst_n   (rst_n),
        .en      (en),
        .up_dn   (up_dn),
        .clr     (clr),
        .load    (load),
        .load_val(load_val),
        .q       (q),
        .tc      (tc),
        .wrap    (wrap),
        .wrap_cnt(wrap_cnt)
`ifdef COUNTER_MOD_N_GRAY_EN
        ,
        .q_gray  (q_gray)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #200 clock = ~clock;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_tc();
        if (!en || clr || load) return 0;
        if (up_dn) return (mq == M - 1) ? 1 : 0;
        return (mq == 0) ? 1 : 0;
    endfunction

    task automatic model_edge();
        int lv;
        lv = int'(load_val);
        if (clr) begin
            mq = 0; mw = 0; mc = 0;
        end else if (load) begin
            mq = (lv >= M) ? M - 1 : lv;
            mw = 0;
        end else if (en) begin
            if (up_dn) begin
                mw = (mq == M - 1) ? 1 : 0;
                mq = (mq + 1) % M;
            end else begin
                mw = (mq == 0) ? 1 : 0;
                mq = (mq + M - 1) % M;
            end
            if (mw == 1 && mc < WMAX) mc++;
        end else begin
            mw = 0;
        end
    endtask

    task automatic tick(input string tag);
        #10;
        chk({tag, ".tc"}, int'(tc), exp_tc());
        @(posedge clock);
        model_edge();
        #1;
        chk({tag, ".q"}, int'(q), mq);
        chk({tag, ".wrap"}, int'(wrap), mw);
        chk({tag, ".wcnt"}, int'(wrap_cnt), mc);
`ifdef COUNTER_MOD_N_GRAY_EN
        if (gray_chk) chk({tag, ".gray"}, int'(q_gray), mq ^ (mq >> 1));
`endif
    endtask

    task automatic drive(input logic e, input logic u, input logic c,
                         input logic l, input logic [W-1:0] v);
        en = e; up_dn = u; clr = c; load = l; load_val = v;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 1, 0, 0, '0);
        #50;
        chk("rst.q", int'(q), 0);
        chk("rst.wrap", int'(wrap), 0);
        chk("rst.wcnt", int'(wrap_cnt), 0);
        @(negedge clock);
        rst_n = 1'b1;

        // 1: count to q=4 with one wrap, then async reset mid-cycle
        drive(1, 1, 0, 0, '0);
        for (int i = 0; i < 10; i++) tick("pre");
        chk("pre.q4", int'(q), 4);
        chk("pre.wc1", int'(wrap_cnt), 1);
        #100;
        rst_n = 1'b0;
        #5;
        chk("arst.q", int'(q), 0);
        chk("arst.wcnt", int'(wrap_cnt), 0);
        mq = 0; mw = 0; mc = 0;
        @(negedge clock);
        rst_n = 1'b1;

        // 2: 13 up edges from 0
        gray_chk = 1;
        drive(1, 1, 0, 0, '0);
        for (int i = 0; i < 13; i++) tick("up");
        gray_chk = 0;
        chk("up.q_end", int'(q), 1);
        chk("up.wc_end", int'(wrap_cnt), 2);

        // 3: down, wrap_cnt saturates
        drive(1, 0, 0, 0, '0);
        tick("dn0");
        chk("dn.at0", int'(q), 0);
        for (int i = 0; i < 13; i++) tick("dn");
        chk("dn.q_end", int'(q), 5);
        chk("dn.wc_sat", int'(wrap_cnt), 3);

        // 4: clamped load, then clr beats load
        drive(0, 1, 0, 1, 3'd7);
        tick("ld7");
        chk("ld7.q", int'(q), 5);
        drive(1, 1, 1, 1, 3'd2);
        tick("clrld");
        chk("clrld.q", int'(q), 0);
        chk("clrld.wc", int'(wrap_cnt), 0);

        // 5: hold at 5 with en=0, then flip direction
        drive(0, 1, 0, 1, 3'd5);
        tick("ld5");
        drive(0, 1, 0, 0, '0);
        tick("hold");
        chk("hold.q", int'(q), 5);
        chk("hold.wrap", int'(wrap), 0);
        drive(1, 0, 0, 0, '0);
        tick("flip");
        chk("flip.q", int'(q), 4);
        chk("flip.wrap", int'(wrap), 0);

        // random phase against the model
        gray_chk = 1;
        for (int i = 0; i < 400; i++) begin
            drive(logic'($urandom_range(0, 3) != 0),
                  logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 31) == 0),
                  logic'($urandom_range(0, 15) == 0),
                  W'($urandom_range(0, 7)));
            tick("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
